rv32im_muldiv_seq: RTL
======================

# rv32im_muldiv_seq

Iterative multiply/divide sequencer for the M-extension in the EX stage of the pipelined RV32IM core. It accepts one MUL/DIV/REM operation from EX and runs a 32-step shift-add multiply or restoring divide. While it computes, it holds the pipeline with a stall request, then returns the result for one cycle. It owns the operand/accumulator registers, the iteration counter, sign fix-up and the RISC-V divide corner cases, so the ALU stays single-cycle.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  EX holds an M-extension instruction. Held high by EX until o_valid.
- i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1_data  in  WIDTH  rs1 operand (dividend / multiplicand).
- i_rs2_data  in  WIDTH  rs2 operand (divisor / multiplier).
- i_flush  in  1  kill the in-flight operation (branch taken / redirect).
- o_stall  out  1  stall request to the hazard logic (freeze IF/ID/EX).
- o_valid  out  1  one-cycle pulse; o_result is valid.
- o_result  out  WIDTH  result for writeback; holds its last value otherwise.

## Operation
- States:
  - IDLE: no operation.
  - CALC: 32 iterations.
  - DONE: result presented.
- Operands and funct3 are latched on the IDLE edge where i_valid=1 and i_flush=0. Inputs are ignored after that edge.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV and REM.
  - rs2 is signed for MULH, DIV and REM.
  - MUL is sign-agnostic (low word).
  - Signed operands are converted to magnitudes at latch time; the result sign is recorded.
- Multiply:
  - 64-bit accumulator; one multiplier bit per iteration, LSB first.
  - In DONE, the 64-bit magnitude is negated if (sign1 XOR sign2).
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring, one quotient bit per iteration, MSB first.
  - Quotient is negated if (sign1 XOR sign2); remainder takes the dividend's sign.
- Fast paths skip CALC (IDLE→DONE):
  - Divisor = 0: quotient = 0xFFFFFFFF and remainder = rs1, for both signed and unsigned.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Transitions:
  - IDLE→CALC on accept.
  - IDLE→DONE on fast-path accept.
  - CALC→DONE when the 5-bit counter = 31 (counter cleared on accept, +1 per CALC cycle).
  - DONE→IDLE unconditionally. No back-to-back restart from the same held i_valid.
- o_stall = !rst & ((IDLE & i_valid & !i_flush) | CALC). It is combinational and deasserted in DONE so EX advances with the result.
- i_flush has priority over everything:
  - In any state, the next state is IDLE.
  - o_valid is not asserted in that cycle or the following one.
  - o_result is unchanged.

## Timing
- Reset values: state IDLE, counter 0, o_valid 0, o_result 0, o_stall 0, internal registers 0.
- Reset mid-operation: the next cycle is IDLE and no o_valid is produced.
- Normal operation, accept edge at end of cycle 0:
  - CALC occupies cycles 1–32.
  - DONE (o_valid=1) is in cycle 33.
  - o_stall is high in cycles 0–32, i.e. 33 stall cycles.
- Fast path: o_stall high in cycle 0 only; o_valid in cycle 1.
- o_result is registered: it changes only on the edge entering DONE and is stable while o_valid=1.
- i_flush and i_valid both high in IDLE: the operation is not accepted and o_stall=0.
- New i_valid in the cycle after DONE is accepted normally, giving a one-cycle IDLE gap.

## Test plan
- **MUL signed:** MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → o_valid in cycle 33, o_result 0xFFFFFFEB. o_stall high for exactly 33 cycles.
- **High-word multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF.
- **Divide by zero:** DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with o_valid in cycle 1 and one stall cycle.
- **Overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, via the fast path.
- **Flush and reset:**
  - i_flush in cycle 10 of CALC → IDLE next cycle, no o_valid, o_stall low.
  - rst in cycle 20 of CALC → all outputs at reset values next cycle.
  - A subsequent MULHU 3 × 4 → 0 completes normally.

Source files
------------

// File: rtl/rv32im_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32im_muldiv_seq_if
//  Purpose  : Handshake/data bundle between the EX stage and the iterative
//             M-extension multiply/divide sequencer.
//  Ports    : (interface signals)
//             i_valid     EX holds an M-extension op (held until o_valid)
//             i_funct3    operation select (MUL..REMU)
//             i_rs1_data  dividend / multiplicand
//             i_rs2_data  divisor / multiplier
//             i_flush     kill in-flight operation
//             o_stall     pipeline stall request
//             o_valid     one-cycle result strobe
//             o_result    registered result
//  Modports : slave  - sequencer side
//             master - EX stage side
//  Revision : 1.0  initial release
// ============================================================================
interface rv32im_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic [2:0]       i_funct3;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic             i_flush;
    logic             o_stall;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;

    modport slave (
        input  i_valid, i_funct3, i_rs1_data, i_rs2_data, i_flush,
        output o_stall, o_valid, o_result
    );

    modport master (
        output i_valid, i_funct3, i_rs1_data, i_rs2_data, i_flush,
        input  o_stall, o_valid, o_result
    );
endinterface
`default_nettype wire

// File: rtl/rv32im_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rv32im_muldiv_seq
//  Purpose  : Iterative RV32M multiply/divide unit. 32-step shift-add
//             multiply (LSB first) and restoring divide (MSB first) on
//             operand magnitudes, with sign fix-up when entering DONE and
//             single-cycle fast paths for divide-by-zero and signed overflow.
//  Ports    : clk  - core clock
//             rst  - synchronous active-high reset
//             bus  - rv32im_muldiv_seq_if.slave (request/stall/result)
//  Revision : 1.0  initial release
// ============================================================================
module rv32im_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rv32im_muldiv_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_int_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
    localparam logic [4:0]       c_last_cnt = 5'd31;

    state_t             r_state;
    state_t             w_next;

    logic [2:0]         r_funct3;
    logic               r_neg_q;     // product / quotient sign
    logic               r_neg_r;     // remainder sign (dividend sign)
    logic [4:0]         r_cnt;
    logic [2*WIDTH-1:0] r_acc;       // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;      // mul: multiplicand magnitude; div: divisor magnitude
    logic [WIDTH-1:0]   r_result;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_is_div;
    logic               w_rs1_signed;
    logic               w_rs2_signed;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_result;

    assign w_accept = (r_state == S_IDLE) && bus.i_valid && !bus.i_flush;
    assign w_is_div = bus.i_funct3[2];

    // MUL is treated as unsigned: its low word is identical either way.
    assign w_rs1_signed = w_is_div ? !bus.i_funct3[0]
                                   : (bus.i_funct3 == 3'b001) || (bus.i_funct3 == 3'b010);
    assign w_rs2_signed = w_is_div ? !bus.i_funct3[0]
                                   : (bus.i_funct3 == 3'b001);

    assign w_neg1 = w_rs1_signed && bus.i_rs1_data[WIDTH-1];
    assign w_neg2 = w_rs2_signed && bus.i_rs2_data[WIDTH-1];
    assign w_mag1 = w_neg1 ? (~bus.i_rs1_data + 1'b1) : bus.i_rs1_data;
    assign w_mag2 = w_neg2 ? (~bus.i_rs2_data + 1'b1) : bus.i_rs2_data;

    assign w_div_zero = w_is_div && (bus.i_rs2_data == '0);
    assign w_div_ovf  = w_is_div && !bus.i_funct3[0]
                        && (bus.i_rs1_data == c_int_min)
                        && (bus.i_rs2_data == c_all_ones);
    assign w_fast     = w_div_zero || w_div_ovf;

    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = bus.i_funct3[1] ? bus.i_rs1_data : c_all_ones;
        end else begin
            w_fast_result = bus.i_funct3[1] ? '0 : c_int_min;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_acc_next;

    // Multiply: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};

    // Divide: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits. A successful subtraction always
    // leaves a value below the divisor, so the low WIDTH bits suffice.
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = w_trial >= {1'b0, r_opnd};
    assign w_diff     = w_trial[WIDTH-1:0] - r_opnd;
    assign w_rem_next = w_ge ? w_diff : w_trial[WIDTH-1:0];

    assign w_acc_next = r_funct3[2] ? {w_rem_next, r_acc[WIDTH-2:0], w_ge}
                                    : {w_sum, r_acc[WIDTH-1:1]};

    // Result as it will stand after the final iteration.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_final;

    assign w_prod = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quo  = r_neg_q ? (~w_acc_next[WIDTH-1:0] + 1'b1) : w_acc_next[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                            : w_acc_next[2*WIDTH-1:WIDTH];

    always_comb begin
        w_final = '0;
        if (r_funct3[2]) begin
            w_final = r_funct3[1] ? w_rem : w_quo;
        end else begin
            w_final = (r_funct3[1:0] == 2'b00) ? w_prod[WIDTH-1:0]
                                               : w_prod[2*WIDTH-1:WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_last_cnt) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.i_flush) begin
            w_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3 <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_funct3 <= bus.i_funct3;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_cnt    <= '0;
            if (w_is_div) begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag1};
                r_opnd <= w_mag2;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_mag2};
                r_opnd <= w_mag1;
            end
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if ((r_state == S_CALC) && !bus.i_flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == c_last_cnt) begin
                r_result <= w_final;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_stall  = !rst && (((r_state == S_IDLE) && bus.i_valid && !bus.i_flush)
                                   || (r_state == S_CALC));
    assign bus.o_valid  = !rst && (r_state == S_DONE) && !bus.i_flush;
    assign bus.o_result = r_result;

endmodule
`default_nettype wire
